// File: rtl/pc_predict_unit_pkg.sv
// Shared definitions for the fetch-side PC / branch prediction unit:
// opcodes, condition codes, flag bit positions and predictor counters.
package pc_predict_unit_pkg;

  // Control-flow opcodes (instr[15:12])
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  // EX opcodes that write all of Z, V and N
  localparam logic [3:0] OP_WR_ZVN_0 = 4'h0;
  localparam logic [3:0] OP_WR_ZVN_1 = 4'h1;

  // EX opcodes that write Z only
  localparam logic [3:0] OP_WR_Z_2 = 4'h2;
  localparam logic [3:0] OP_WR_Z_4 = 4'h4;
  localparam logic [3:0] OP_WR_Z_5 = 4'h5;
  localparam logic [3:0] OP_WR_Z_6 = 4'h6;

  // Branch condition codes (instr[11:9])
  typedef enum logic [2:0] {
    CC_NE = 3'b000,  // Z=0
    CC_EQ = 3'b001,  // Z=1
    CC_GT = 3'b010,  // Z=0 and N=0
    CC_LT = 3'b011,  // N=1
    CC_GE = 3'b100,  // Z=1 or (Z=0 and N=0)
    CC_LE = 3'b101,  // Z=1 or N=1
    CC_OV = 3'b110,  // V=1
    CC_AL = 3'b111   // always
  } cond_e;

  // Bit positions inside a {Z,V,N} flag vector
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // 2-bit saturating predictor counter; >= CTR_WT predicts taken
  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Saturating step towards the resolved direction
  function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != CTR_ST) r = c + 2'd1;
    end else begin
      if (c != CTR_SNT) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational flag bypass and branch condition evaluator. Produces the
// effective {Z,V,N} (EX writes this cycle override the stored flags) and
// whether the given condition code holds on them.
module branch_cond_eval
  import pc_predict_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags_state,
  input  logic       ex_valid,
  input  logic [3:0] ex_opcode,
  input  logic [2:0] ex_flags,
  output logic [2:0] eff_flags,
  output logic       cond_true
);

  logic wr_zvn;
  logic wr_z;
  logic z;
  logic v;
  logic n;

  // Decode which flag fields EX writes and merge them over the stored flags
  always_comb begin
    wr_zvn    = ex_valid && (ex_opcode inside {OP_WR_ZVN_0, OP_WR_ZVN_1});
    wr_z      = ex_valid && (ex_opcode inside {OP_WR_Z_2, OP_WR_Z_4, OP_WR_Z_5, OP_WR_Z_6});
    eff_flags = flags_state;
    if (wr_zvn) begin
      eff_flags = ex_flags;
    end else if (wr_z) begin
      eff_flags[FLAG_Z] = ex_flags[FLAG_Z];
    end
  end

  assign z = eff_flags[FLAG_Z];
  assign v = eff_flags[FLAG_V];
  assign n = eff_flags[FLAG_N];

  // Evaluate the condition code on the effective flags
  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond))
      CC_NE:   cond_true = !z;
      CC_EQ:   cond_true = z;
      CC_GT:   cond_true = !z && !n;
      CC_LT:   cond_true = n;
      CC_GE:   cond_true = z || (!z && !n);
      CC_LE:   cond_true = z || n;
      CC_OV:   cond_true = v;
      CC_AL:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-side PC unit: PC register, {Z,V,N} flag register and a table of
// 2-bit branch predictors. B is predicted in IF and resolved in ID; a
// mispredict flushes IF/ID and redirects the PC on the following edge.
module pc_predict_unit
  import pc_predict_unit_pkg::*;
#(
  parameter int                 DATA_W    = 16,
  parameter int                 BHT_DEPTH = 16,
  parameter logic [DATA_W-1:0]  RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr_if,
  input  logic              stall,
  input  logic              id_valid,
  input  logic [15:0]       id_instr,
  input  logic [DATA_W-1:0] id_pc_inc,
  input  logic              id_pred_taken,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [3:0]        ex_opcode,
  input  logic              ex_valid,
  input  logic [2:0]        ex_flags,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pc_inc,
  output logic              pred_taken,
  output logic              flush,
  output logic              halted
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] pc_next;
  logic [2:0]        flags_reg;
  logic [2:0]        flags_next;
  logic [0:0]        state_reg;
  logic [0:0]        state_next;
  ctr_t              bht_reg [BHT_DEPTH];

  logic [IDX_W-1:0]  if_idx;
  logic [IDX_W-1:0]  id_idx;
  logic [DATA_W-1:0] if_off;
  logic [DATA_W-1:0] id_off;
  logic [DATA_W-1:0] actual_target;
  logic [2:0]        eff_flags;
  logic              cond_true;
  logic              running;
  logic              id_active;
  logic              is_b_id;
  logic              is_br_id;
  logic              is_hlt_id;
  logic              mispredict;
  logic              hlt_id;
  logic              bht_we;
  ctr_t              bht_wdata;

  // The IF condition field is not needed: only the counter decides IF direction
  logic unused_if_cond;
  assign unused_if_cond = ^instr_if[11:9];

  assign running = (state_reg == ST_RUN);
  assign pc      = pc_reg;
  assign pc_inc  = pc_reg + DATA_W'(2);
  assign halted  = (state_reg == ST_HALT);

  // Table index: halfword address bits of the instruction's own PC
  assign if_idx = IDX_W'(pc_reg >> 1);
  assign id_idx = IDX_W'((id_pc_inc - DATA_W'(2)) >> 1);

  // Sign-extended 9-bit word offset, scaled to bytes
  assign if_off = {{(DATA_W-10){instr_if[8]}}, instr_if[8:0], 1'b0};
  assign id_off = {{(DATA_W-10){id_instr[8]}}, id_instr[8:0], 1'b0};

  branch_cond_eval u_cond (
    .cond        (id_instr[11:9]),
    .flags_state (flags_reg),
    .ex_valid    (ex_valid),
    .ex_opcode   (ex_opcode),
    .ex_flags    (ex_flags),
    .eff_flags   (eff_flags),
    .cond_true   (cond_true)
  );

  // IF prediction: only B can be predicted taken
  assign pred_taken = (instr_if[15:12] == OP_B) && (bht_reg[if_idx] >= CTR_WT);

  // ID resolution, flush and next-state selection
  always_comb begin
    is_b_id       = (id_instr[15:12] == OP_B);
    is_br_id      = (id_instr[15:12] == OP_BR);
    is_hlt_id     = (id_instr[15:12] == OP_HLT);
    id_active     = running && id_valid && !stall;
    mispredict    = id_active && (is_b_id || is_br_id) && (cond_true != id_pred_taken);
    hlt_id        = id_active && is_hlt_id;
    actual_target = is_br_id ? rs_val : (id_pc_inc + id_off);
    flush         = mispredict || hlt_id || !running;

    if (mispredict) begin
      pc_next = cond_true ? actual_target : id_pc_inc;
    end else if (hlt_id || stall || !running) begin
      pc_next = pc_reg;
    end else if (pred_taken) begin
      pc_next = pc_inc + if_off;
    end else begin
      pc_next = pc_inc;
    end

    state_next = hlt_id ? ST_HALT : state_reg;
    flags_next = running ? eff_flags : flags_reg;
    bht_we     = id_active && is_b_id;
    bht_wdata  = ctr_update(bht_reg[id_idx], cond_true);
  end

  // State registers; reset overrides halt, stall and redirects
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      flags_reg <= 3'b000;
      state_reg <= ST_RUN;
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_reg[i] <= CTR_WNT;
      end
    end else begin
      pc_reg    <= pc_next;
      flags_reg <= flags_next;
      state_reg <= state_next;
      if (bht_we) begin
        bht_reg[id_idx] <= bht_wdata;
      end
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Scoreboard bench for pc_predict_unit: the driver pushes the expected
// outputs of each cycle from a spec-level reference model; a monitor pops
// and compares on the falling edge.
module tb_pc_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_if;
  logic        stall;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc_inc;
  logic        id_pred_taken;
  logic [15:0] rs_val;
  logic [3:0]  ex_opcode;
  logic        ex_valid;
  logic [2:0]  ex_flags;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic        pred_taken;
  logic        flush;
  logic        halted;

  pc_predict_unit #(.DATA_W(16), .BHT_DEPTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .instr_if(instr_if), .stall(stall),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc_inc(id_pc_inc),
    .id_pred_taken(id_pred_taken), .rs_val(rs_val), .ex_opcode(ex_opcode),
    .ex_valid(ex_valid), .ex_flags(ex_flags), .pc(pc), .pc_inc(pc_inc),
    .pred_taken(pred_taken), .flush(flush), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] inc;
    logic        pred;
    logic        flush;
    logic        halted;
    logic        comb;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int txn = 0;

  // Reference model state
  logic [15:0] m_pc;
  bit          m_z, m_v, m_n;
  int          m_ctr[16];
  bit          m_halt;
  bit          m_known = 0;

  // Last-cycle outputs of the model, used to build the IF/ID pipeline
  bit          l_flush, l_pred;
  logic [15:0] l_inc;

  // Pipeline model feeding the ID inputs in random mode
  bit          p_v;
  logic [15:0] p_i, p_pc;
  bit          p_p;
  logic [15:0] imem[64];

  localparam logic [15:0] NOP = 16'h3000;

  function automatic bit holds(input int c, input bit z, input bit v, input bit n);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return z || n;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int off_bytes(input logic [15:0] w);
    int o;
    o = int'(w[8:0]);
    if (o >= 256) o = o - 512;
    return 2 * o;
  endfunction

  // One cycle: drive inputs, push expected outputs, advance the model
  task automatic step(input bit r, input logic [15:0] iif, input bit st,
                      input bit idv, input logic [15:0] idi, input logic [15:0] idpc,
                      input bit idp, input logic [15:0] rs, input logic [3:0] exop,
                      input bit exv, input logic [2:0] exf);
    bit z, v, n, hold, br, taken, misp, hlt, active, e_pred, e_flush;
    logic [15:0] e_inc, tgt;
    exp_t e;
    int idx;
    rst = r; instr_if = iif; stall = st; id_valid = idv; id_instr = idi;
    id_pc_inc = idpc; id_pred_taken = idp; rs_val = rs;
    ex_opcode = exop; ex_valid = exv; ex_flags = exf;

    z = m_z; v = m_v; n = m_n;
    if (exv && (exop == 4'h0 || exop == 4'h1)) begin
      z = exf[2]; v = exf[1]; n = exf[0];
    end else if (exv && (exop == 4'h2 || exop == 4'h4 || exop == 4'h5 || exop == 4'h6)) begin
      z = exf[2];
    end
    e_inc   = m_pc + 16'd2;
    e_pred  = (iif[15:12] == 4'hC) && (m_ctr[(m_pc / 2) % 16] >= 2);
    active  = !m_halt && idv && !st;
    br      = (idi[15:12] == 4'hC) || (idi[15:12] == 4'hD);
    hold    = holds(int'(idi[11:9]), z, v, n);
    taken   = br && hold;
    misp    = active && br && (hold != idp);
    hlt     = active && (idi[15:12] == 4'hF);
    e_flush = misp || hlt || m_halt;
    tgt     = (idi[15:12] == 4'hD) ? rs : 16'(int'(idpc) + off_bytes(idi));

    if (m_known) begin
      e.pc = m_pc; e.inc = e_inc; e.pred = e_pred; e.flush = e_flush;
      e.halted = m_halt; e.comb = !r;
      sb.push_back(e);
    end
    l_flush = e_flush; l_pred = e_pred; l_inc = e_inc;

    if (r) begin
      m_pc = 16'h0000; m_z = 0; m_v = 0; m_n = 0; m_halt = 0;
      for (int i = 0; i < 16; i++) m_ctr[i] = 1;
      m_known = 1;
    end else if (!m_halt) begin
      if (misp) m_pc = taken ? tgt : idpc;
      else if (hlt || st) m_pc = m_pc;
      else if (e_pred) m_pc = 16'(int'(e_inc) + off_bytes(iif));
      else m_pc = e_inc;
      if (hlt) m_halt = 1;
      m_z = z; m_v = v; m_n = n;
      if (active && idi[15:12] == 4'hC) begin
        idx = ((int'(idpc) - 2) / 2) % 16;
        if (idx < 0) idx = idx + 16;
        if (hold && m_ctr[idx] < 3) m_ctr[idx]++;
        if (!hold && m_ctr[idx] > 0) m_ctr[idx]--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Directed cycle: no reset, no EX flag write unless given
  task automatic d(input logic [15:0] iif, input bit idv, input logic [15:0] idi,
                   input logic [15:0] idpc, input bit idp, input logic [15:0] rs,
                   input bit st, input logic [3:0] exop, input bit exv, input logic [2:0] exf);
    step(1'b0, iif, st, idv, idi, idpc, idp, rs, exop, exv, exf);
  endtask

  // Random cycle with a consistent IF/ID pipeline around the unit
  task automatic auto_cycle();
    bit r, st;
    logic [15:0] iif;
    r   = (m_halt && $urandom_range(0, 7) == 0) || ($urandom_range(0, 499) == 0);
    st  = ($urandom_range(0, 9) == 0);
    iif = imem[(m_pc / 2) % 64];
    step(r, iif, st, p_v, p_i, p_pc, p_p, 16'($urandom_range(0, 127) * 2),
         4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    if (r || l_flush) begin
      p_v = 0;
    end else if (!st) begin
      p_v = 1; p_i = iif; p_pc = l_inc; p_p = l_pred;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s txn=%0d actual=%h required=%h", name, txn, act, exp_v);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare against the next entry
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      txn++;
      chk("pc", int'(pc), int'(e.pc));
      chk("halted", int'(halted), int'(e.halted));
      if (e.comb) begin
        chk("pc_inc", int'(pc_inc), int'(e.inc));
        chk("pred_taken", int'(pred_taken), int'(e.pred));
        chk("flush", int'(flush), int'(e.flush));
      end
      $display("txn %0d pc=%h pc_inc=%h pred=%0d flush=%0d halted=%0d", txn, pc, pc_inc,
               pred_taken, flush, halted);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    rst = 1; instr_if = NOP; stall = 0; id_valid = 0; id_instr = NOP; id_pc_inc = 0;
    id_pred_taken = 0; rs_val = 0; ex_opcode = 4'h3; ex_valid = 0; ex_flags = 0;
    @(posedge clk);
    #1;

    // Reset then idle nops
    step(1, NOP, 0, 0, NOP, 0, 0, 0, 4'h3, 0, 0);
    step(1, NOP, 0, 0, NOP, 0, 0, 0, 4'h3, 0, 0);
    guard = 0;
    while (m_pc != 16'h0010 && guard < 20) begin
      d(NOP, 0, NOP, 0, 0, 0, 0, 4'h3, 0, 0);
      guard++;
    end

    // B always at 0x10: first predicted not-taken, mispredicts to 0x1C
    d(16'hCE05, 0, NOP, 0, 0, 0, 0, 4'h3, 0, 0);
    d(NOP, 1, 16'hCE05, 16'h0012, 0, 0, 0, 4'h3, 0, 0);
    // BR always at 0x1C back to 0x10
    d(16'hDE00, 0, NOP, 0, 0, 0, 0, 4'h3, 0, 0);
    d(NOP, 1, 16'hDE00, 16'h001E, 0, 16'h0010, 0, 4'h3, 0, 0);
    // Second fetch of the B now predicts taken, resolves without flush
    d(16'hCE05, 0, NOP, 0, 0, 0, 0, 4'h3, 0, 0);
    d(NOP, 1, 16'hCE05, 16'h0012, 1, 0, 0, 4'h3, 0, 0);

    // Flag bypass: EX writes Z=1 in the same cycle as B EQ / B NE in ID
    d(NOP, 1, 16'hC203, 16'h0040, 0, 0, 0, 4'h1, 1, 3'b100);
    d(NOP, 1, 16'hC003, 16'h0050, 0, 0, 0, 4'h1, 1, 3'b100);
    // Z-only writer clears Z while stored Z=1: predicted-taken B EQ mispredicts
    d(NOP, 1, 16'hC203, 16'h0060, 1, 0, 0, 4'h2, 1, 3'b000);

    // BR redirect to 0x0400; index 0 counter untouched
    d(NOP, 1, 16'hDE00, 16'h0022, 0, 16'h0400, 0, 4'h3, 0, 0);
    d(16'hCE05, 0, NOP, 0, 0, 0, 0, 4'h3, 0, 0);

    // Stall hides a mispredicting B until released
    d(NOP, 1, 16'hCE07, 16'h0100, 0, 0, 1, 4'h3, 0, 0);
    d(NOP, 1, 16'hCE07, 16'h0100, 0, 0, 0, 4'h3, 0, 0);

    // HLT in ID, then frozen for 10 cycles despite branch activity
    d(NOP, 1, 16'hF000, 16'h0200, 0, 0, 0, 4'h3, 0, 0);
    for (int i = 0; i < 10; i++) begin
      d(16'hCE05, 1, 16'hCE03, 16'h0300, 0, 16'h0700, 1'($urandom_range(0, 1)), 4'h0, 1, 3'b111);
    end
    step(1, NOP, 0, 0, NOP, 0, 0, 0, 4'h3, 0, 0);
    d(NOP, 0, NOP, 0, 0, 0, 0, 4'h3, 0, 0);
    d(NOP, 0, NOP, 0, 0, 0, 0, 4'h3, 0, 0);

    // Random program with pipeline-consistent ID inputs
    for (int i = 0; i < 64; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 40) imem[i] = {4'h3, 12'($urandom)};
      else if (sel < 65) imem[i] = {4'hC, 3'($urandom_range(0, 7)), 9'($urandom_range(0, 16) - 8)};
      else if (sel < 75) imem[i] = {4'hD, 3'($urandom_range(0, 7)), 9'h000};
      else if (sel < 98) imem[i] = {4'($urandom_range(0, 6)), 12'($urandom)};
      else imem[i] = 16'hF000;
    end
    p_v = 0; p_i = NOP; p_pc = 0; p_p = 0;
    step(1, NOP, 0, 0, NOP, 0, 0, 0, 4'h3, 0, 0);
    for (int i = 0; i < 3000; i++) auto_cycle();

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
